// File: rtl/bias_upd_pkg.sv
// Shared widths and FSM encoding for the bias update controller.
package bias_upd_pkg;
    localparam int DWIDTH = 16;
    localparam int AWIDTH = 10;
    localparam int NMAX   = 16;
    localparam int IDXW   = 4;   // neuron index width, covers 0..NMAX-1

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        CALC,
        WRITE,
        DONE
    } state_t;
endpackage

// File: rtl/bias_update_ctrl_if.sv
// Bias BRAM port bundle: controller drives address/write side, memory returns read data.
interface bias_update_ctrl_if #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 16
);
    logic [AWIDTH-1:0] bram_addr;
    logic              bram_we;
    logic [DWIDTH-1:0] bram_din;
    logic [DWIDTH-1:0] bram_dout;

    modport master (output bram_addr, output bram_we, output bram_din, input bram_dout);
    modport slave  (input bram_addr, input bram_we, input bram_din, output bram_dout);
endinterface

// File: rtl/bias_index_counter.sv
// Neuron index generator: holds the pass base/count, walks the index and
// produces the wrapped bias address plus a last-neuron flag.
module bias_index_counter
    import bias_upd_pkg::*;
#(
    parameter int AWIDTH = bias_upd_pkg::AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [AWIDTH-1:0] base_in,
    input  logic [4:0]        n_in,
    output logic [IDXW-1:0]   idx,
    output logic [AWIDTH-1:0] addr,
    output logic              last
);
    logic [AWIDTH-1:0] base_q;
    logic [4:0]        n_q;
    logic [IDXW-1:0]   idx_q;

    // Latch pass parameters on clear, otherwise step the index on request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            n_q    <= '0;
            idx_q  <= '0;
        end else if (clr) begin
            base_q <= base_in;
            n_q    <= n_in;
            idx_q  <= '0;
        end else if (inc) begin
            idx_q  <= idx_q + 1'b1;
        end
    end

    // Address wraps naturally in AWIDTH bits.
    always_comb begin
        idx  = idx_q;
        addr = base_q + AWIDTH'(idx_q);
        last = (5'(idx_q) == (n_q - 5'd1));
    end
endmodule

// File: rtl/bias_update_ctrl.sv
// Bias update sequencer: for each neuron reads bias and delta, hands them to
// the external calculation stage, then writes the returned bias back in place.
module bias_update_ctrl
    import bias_upd_pkg::*;
#(
    parameter int DWIDTH       = bias_upd_pkg::DWIDTH,
    parameter int AWIDTH       = bias_upd_pkg::AWIDTH,
    parameter int HiddenNeuron = bias_upd_pkg::NMAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [4:0]         n_neurons,
    input  logic [AWIDTH-1:0]  base_addr,
    output logic [3:0]         delta_addr,
    input  logic [DWIDTH-1:0]  delta_in,
    bias_update_ctrl_if.master bram,
    output logic [DWIDTH-1:0]  calc_delta,
    output logic [DWIDTH-1:0]  calc_bias,
    output logic               en_b_back,
    input  logic [DWIDTH-1:0]  new_bias,
    output logic               busy,
    output logic               done
);
    state_t            state_q, state_d;
    logic [DWIDTH-1:0] bias_q, delta_q;
    logic [4:0]        n_eff;
    logic              cnt_clr, cnt_inc, cnt_last;
    logic [IDXW-1:0]   idx;
    logic [AWIDTH-1:0] addr;

    assign n_eff = (n_neurons > 5'(HiddenNeuron)) ? 5'(HiddenNeuron) : n_neurons;

    bias_index_counter #(.AWIDTH(AWIDTH)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .base_in (base_addr),
        .n_in    (n_eff),
        .idx     (idx),
        .addr    (addr),
        .last    (cnt_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Capture BRAM and delta read data, which land one cycle after READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_q  <= '0;
            delta_q <= '0;
        end else if (state_q == WAIT) begin
            bias_q  <= bram.bram_dout;
            delta_q <= delta_in;
        end
    end

    // Next-state and output decode; all outputs are idle-zero outside their state,
    // so an async reset clears them immediately.
    always_comb begin
        state_d        = state_q;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        bram.bram_addr = '0;
        bram.bram_we   = 1'b0;
        bram.bram_din  = '0;
        delta_addr     = '0;
        calc_bias      = '0;
        calc_delta     = '0;
        en_b_back      = 1'b0;
        done           = 1'b0;
        busy           = (state_q != IDLE);
        case (state_q)
            IDLE: if (start) begin
                cnt_clr = 1'b1;
                state_d = (n_eff == 5'd0) ? DONE : READ;
            end
            READ: begin
                bram.bram_addr = addr;
                delta_addr     = 4'(idx);
                state_d        = WAIT;
            end
            WAIT: state_d = CALC;
            CALC: begin
                calc_bias  = bias_q;
                calc_delta = delta_q;
                en_b_back  = 1'b1;
                state_d    = WRITE;
            end
            WRITE: begin
                bram.bram_addr = addr;
                bram.bram_we   = 1'b1;
                bram.bram_din  = new_bias;
                if (cnt_last) begin
                    state_d = DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = READ;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
